// File: rtl/ir_pdm_pkg.sv
// Shared types and constants for the IR PDM transmit path.
package ir_pdm_pkg;

    localparam int IR_SYM_W = 5;
    localparam logic [IR_SYM_W-1:0] IR_SYM_IDLE = 5'h10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT_DONE,
        GAP
    } state_t;

    typedef struct packed {
        logic                last;
        logic [IR_SYM_W-1:0] data;
    } fifo_entry_t;

    // Number of bits needed to hold values 0..maxVal (never less than one).
    function automatic int bits_for(input int maxVal);
        bits_for = (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/pdm_clk_div.sv
// Free-running divider: a square wave that toggles every HALF clk cycles,
// plus a one-cycle strobe in the first clk cycle the wave is high.
module pdm_clk_div
    import ir_pdm_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rstn,
    output logic o_wave,
    output logic o_rise
);

    localparam int CW = bits_for(HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_wave;
    logic          r_rise;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(HALF - 1));

    // Half-period counter, wave toggle and registered rising-edge strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_wave <= ~r_wave;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
            r_rise <= w_wrap && !r_wave;
        end
    end

    assign o_wave = r_wave;
    assign o_rise = r_rise;

endmodule

// File: rtl/ir_pdm_tx_scheduler.sv
// IR PDM transmit scheduler: buffers symbols, generates ock/bck, and hands
// one symbol at a time to the modulator, framing with an inter-frame gap.
module ir_pdm_tx_scheduler
    import ir_pdm_pkg::*;
#(
    parameter int OCK_HALF    = 2,
    parameter int BCK_HALF    = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_BCK     = 2,
    parameter int TIMEOUT_BCK = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IR_SYM_W-1:0] s_data,
    input  logic                s_last,
    output logic                ock,
    output logic                bck,
    output logic                load,
    output logic [IR_SYM_W-1:0] mod_din,
    input  logic                mod_done,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun,
    output logic                timeout
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = bits_for(FIFO_DEPTH);
    localparam int BCK_MAX = (TIMEOUT_BCK > GAP_BCK) ? TIMEOUT_BCK : GAP_BCK;
    localparam int BW    = bits_for(BCK_MAX);

    // Clock dividers
    logic w_ock;
    logic w_unused_ock_rise;
    logic w_bck;
    logic w_bck_rise;

    pdm_clk_div #(.HALF(OCK_HALF)) u_ock_div (
        .clk    (clk),
        .rstn   (rstn),
        .o_wave (w_ock),
        .o_rise (w_unused_ock_rise)
    );

    pdm_clk_div #(.HALF(BCK_HALF)) u_bck_div (
        .clk    (clk),
        .rstn   (rstn),
        .o_wave (w_bck),
        .o_rise (w_bck_rise)
    );

    // Symbol FIFO
    fifo_entry_t       r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    fifo_entry_t       w_head;
    fifo_entry_t       w_wr_entry;

    // Scheduler state
    state_t            r_state;
    state_t            w_next;
    logic [BW-1:0]     r_bck_cnt;
    logic [IR_SYM_W-1:0] r_mod_din;
    logic              r_cur_last;
    logic              r_frame_done;
    logic              r_underrun;
    logic              r_timeout;
    logic              w_frame_done;
    logic              w_underrun;
    logic              w_timeout;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNTW'(FIFO_DEPTH));
    assign w_push     = s_valid && !w_full;
    assign w_pop      = (r_state == LOAD);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_wr_entry = '{last: s_last, data: s_data};

    // Storage array needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state decode and one-cycle event flags.
    always_comb begin
        w_next       = r_state;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en && !w_empty) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = ARM;
            end
            ARM: begin
                w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mod_done) begin
                    if (r_cur_last) begin
                        w_next       = GAP;
                        w_frame_done = 1'b1;
                    end else if (!w_empty) begin
                        w_next = LOAD;
                    end else begin
                        w_next     = IDLE;
                        w_underrun = 1'b1;
                    end
                end else if (w_bck_rise && (r_bck_cnt == BW'(TIMEOUT_BCK - 1))) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            GAP: begin
                if (w_bck_rise && (r_bck_cnt == BW'(GAP_BCK - 1))) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // bck-edge counter shared by WAIT_DONE timeout and GAP; cleared on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bck_cnt <= '0;
        end else if (w_next != r_state) begin
            r_bck_cnt <= '0;
        end else if (w_bck_rise && ((r_state == WAIT_DONE) || (r_state == GAP))) begin
            r_bck_cnt <= r_bck_cnt + 1'b1;
        end
    end

    // Capture head symbol on entry to LOAD so mod_din is valid alongside the load strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mod_din  <= IR_SYM_IDLE;
            r_cur_last <= 1'b0;
        end else if ((w_next == LOAD) && (r_state != LOAD)) begin
            r_mod_din  <= w_head.data;
            r_cur_last <= w_head.last;
        end
    end

    // Register the event pulses so each is exactly one clean cycle wide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_done;
            r_underrun   <= w_underrun;
            r_timeout    <= w_timeout;
        end
    end

    assign s_ready    = !w_full;
    assign ock        = w_ock;
    assign bck        = w_bck;
    assign load       = (r_state == LOAD);
    assign mod_din    = r_mod_din;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_ir_pdm_tx_scheduler.sv
// Directed bench for ir_pdm_tx_scheduler with a small behavioural modulator load.
module tb_ir_pdm_tx_scheduler;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic [4:0] s_data = 5'h00;
    logic       s_ready, ock, bck, load, busy, frame_done, underrun, timeout;
    logic [4:0] mod_din;
    logic       mod_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ir_pdm_tx_scheduler #(
        .OCK_HALF(2), .BCK_HALF(8), .FIFO_DEPTH(4), .GAP_BCK(2), .TIMEOUT_BCK(24)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .ock(ock), .bck(bck), .load(load), .mod_din(mod_din), .mod_done(mod_done),
        .busy(busy), .frame_done(frame_done), .underrun(underrun), .timeout(timeout)
    );

    // Modulator model: 5'h10 finishes at once, others after din[3:0] bck rises.
    logic       m_done, m_active, m_bck_prev;
    logic [3:0] m_target, m_cnt;
    bit         force_low = 1'b0;

    assign mod_done = m_done && !force_low;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_done <= 1'b0; m_active <= 1'b0; m_bck_prev <= 1'b0;
            m_target <= 4'd0; m_cnt <= 4'd0;
        end else begin
            m_bck_prev <= bck;
            if (load) begin
                if (mod_din == 5'h10) begin
                    m_done <= 1'b1; m_active <= 1'b0;
                end else begin
                    m_done <= 1'b0; m_active <= 1'b1;
                    m_cnt <= 4'd0; m_target <= mod_din[3:0];
                end
            end else if (m_active && bck && !m_bck_prev) begin
                m_cnt <= m_cnt + 4'd1;
                if (m_cnt + 4'd1 == m_target) begin
                    m_done <= 1'b1; m_active <= 1'b0;
                end
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int load_cnt = 0, fd_cnt = 0, un_cnt = 0, to_cnt = 0;
    int rise_total = 0, arm_snap = 0, to_rises = 0, gap_rises = 0;
    bit gap_track = 0, load_d1 = 0, bck_prev_n = 0;
    logic [4:0] load_q[$];
    int load_cyc[$];

    always @(negedge clk) begin
        if (!rstn) begin
            bck_prev_n = 0; load_d1 = 0; gap_track = 0;
        end else begin
            if (frame_done) begin gap_track = 1; gap_rises = 0; end
            if (gap_track && !busy) gap_track = 0;
            if (gap_track && bck && !bck_prev_n) gap_rises++;
            if (timeout) begin to_cnt++; to_rises = rise_total - arm_snap; end
            if (bck && !bck_prev_n) rise_total++;
            if (load_d1) arm_snap = rise_total;
            load_d1 = load;
            if (load) begin load_cnt++; load_q.push_back(mod_din); load_cyc.push_back(cyc); end
            if (frame_done) fd_cnt++;
            if (underrun) un_cnt++;
            bck_prev_n = bck;
        end
    end

    task automatic clear_stats();
        load_cnt = 0; fd_cnt = 0; un_cnt = 0; to_cnt = 0;
        to_rises = 0; gap_rises = 0;
        load_q.delete(); load_cyc.delete();
    endtask

    task automatic push(input logic [4:0] d, input logic l, output bit ok, output int acc);
        ok = 0; acc = -1;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int i = 0; i < 2000; i++) begin
            if (s_ready) begin
                ok = 1; acc = cyc;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input int maxCyc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok; int acc;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({ock, bck, load, frame_done, underrun, timeout} !== 6'b0) begin bad++; $display("[TB] FAIL reset_strobes: got %b want 000000", {ock, bck, load, frame_done, underrun, timeout}); end
        total++; if (mod_din !== 5'h10) begin bad++; $display("[TB] FAIL reset_mod_din: got %h want 10", mod_din); end
        total++; if (s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_busy: got %b%b want 10", s_ready, busy); end
        rstn = 1'b1; en = 1'b1;
        clear_stats();
        push(5'h1F, 1'b1, ok, acc);
        push(5'h03, 1'b0, ok, acc);
        for (int i = 0; i < 50 && load_cnt == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midop_busy: got %b want 1", busy); end
        #2 rstn = 1'b0;
        #1;
        total++; if ({ock, bck, load, frame_done, underrun, timeout} !== 6'b0) begin bad++; $display("[TB] FAIL midrst_strobes: got %b want 000000", {ock, bck, load, frame_done, underrun, timeout}); end
        total++; if (mod_din !== 5'h10) begin bad++; $display("[TB] FAIL midrst_mod_din: got %h want 10", mod_din); end
        total++; if (s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready_busy: got %b%b want 10", s_ready, busy); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        clear_stats();
        repeat (40) @(negedge clk);
        total++; if (load_cnt !== 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL fifo_discarded: loads=%0d busy=%b want 0 0", load_cnt, busy); end
    endtask

    task automatic test_single_frame();
        bit ok; int acc; logic [4:0] d0;
        clear_stats(); en = 1'b1;
        push(5'h14, 1'b1, ok, acc);
        wait_not_busy(400, ok);
        d0 = (load_q.size() > 0) ? load_q[0] : 5'h00;
        total++; if (!ok) begin bad++; $display("[TB] FAIL single_idle: busy still %b after bound, want 0", busy); end
        total++; if (load_cnt !== 1) begin bad++; $display("[TB] FAIL single_load_cycles: got %0d want 1", load_cnt); end
        total++; if (d0 !== 5'h14) begin bad++; $display("[TB] FAIL single_mod_din: got %h want 14", d0); end
        total++; if (fd_cnt !== 1) begin bad++; $display("[TB] FAIL single_frame_done: got %0d want 1", fd_cnt); end
        total++; if (gap_rises !== 2) begin bad++; $display("[TB] FAIL single_gap_bck: got %0d want 2", gap_rises); end
        total++; if (un_cnt !== 0 || to_cnt !== 0) begin bad++; $display("[TB] FAIL single_errors: un=%0d to=%0d want 0 0", un_cnt, to_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok; int acc; logic [14:0] seq; int gap;
        clear_stats(); en = 1'b1;
        push(5'h0C, 1'b0, ok, acc);
        push(5'h10, 1'b0, ok, acc);
        push(5'h1F, 1'b1, ok, acc);
        wait_not_busy(1500, ok);
        seq = (load_q.size() == 3) ? {load_q[0], load_q[1], load_q[2]} : 15'h0;
        gap = (load_cyc.size() == 3) ? load_cyc[2] - load_cyc[1] : -1;
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_idle: busy still %b after bound, want 0", busy); end
        total++; if (load_cnt !== 3) begin bad++; $display("[TB] FAIL b2b_loads: got %0d want 3", load_cnt); end
        total++; if (seq !== {5'h0C, 5'h10, 5'h1F}) begin bad++; $display("[TB] FAIL b2b_order: got %h want %h", seq, {5'h0C, 5'h10, 5'h1F}); end
        total++; if (gap !== 3) begin bad++; $display("[TB] FAIL b2b_idle_sym_cycles: got %0d want 3", gap); end
        total++; if (fd_cnt !== 1 || un_cnt !== 0) begin bad++; $display("[TB] FAIL b2b_frame: fd=%0d un=%0d want 1 0", fd_cnt, un_cnt); end
    endtask

    task automatic test_fifo_full();
        bit ok, ok5; int acc, acc5, rel; logic [24:0] seq;
        clear_stats(); en = 1'b0;
        push(5'h02, 1'b0, ok, acc);
        push(5'h03, 1'b0, ok, acc);
        push(5'h01, 1'b0, ok, acc);
        push(5'h02, 1'b0, ok, acc);
        @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b want 0", s_ready); end
        total++; if (busy !== 1'b1 || load_cnt !== 0) begin bad++; $display("[TB] FAIL full_held: busy=%b loads=%0d want 1 0", busy, load_cnt); end
        fork
            push(5'h10, 1'b1, ok5, acc5);
            begin repeat (6) @(negedge clk); en = 1'b1; end
        join
        rel = (load_cyc.size() > 0) ? acc5 - load_cyc[0] : -1;
        total++; if (!ok5 || rel !== 1) begin bad++; $display("[TB] FAIL full_accept_after_pop: ok=%0d offset=%0d want 1 1", ok5, rel); end
        wait_not_busy(3000, ok);
        seq = (load_q.size() == 5) ? {load_q[0], load_q[1], load_q[2], load_q[3], load_q[4]} : 25'h0;
        total++; if (!ok || load_cnt !== 5) begin bad++; $display("[TB] FAIL full_loads: idle=%0d loads=%0d want 1 5", ok, load_cnt); end
        total++; if (seq !== {5'h02, 5'h03, 5'h01, 5'h02, 5'h10}) begin bad++; $display("[TB] FAIL full_order: got %h want %h", seq, {5'h02, 5'h03, 5'h01, 5'h02, 5'h10}); end
        total++; if (fd_cnt !== 1) begin bad++; $display("[TB] FAIL full_frame_done: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_underrun();
        bit ok; int acc;
        clear_stats(); en = 1'b1;
        push(5'h12, 1'b0, ok, acc);
        wait_not_busy(400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL underrun_idle: busy still %b after bound, want 0", busy); end
        total++; if (un_cnt !== 1) begin bad++; $display("[TB] FAIL underrun_pulse: got %0d want 1", un_cnt); end
        total++; if (fd_cnt !== 0 || load_cnt !== 1) begin bad++; $display("[TB] FAIL underrun_other: fd=%0d loads=%0d want 0 1", fd_cnt, load_cnt); end
    endtask

    task automatic test_timeout();
        bit ok; int acc; logic [4:0] d1;
        clear_stats(); en = 1'b1; force_low = 1'b1;
        push(5'h05, 1'b0, ok, acc);
        push(5'h10, 1'b1, ok, acc);
        for (int i = 0; i < 600 && to_cnt == 0; i++) begin @(negedge clk); #1; end
        force_low = 1'b0;
        total++; if (to_cnt !== 1) begin bad++; $display("[TB] FAIL timeout_pulse: got %0d want 1", to_cnt); end
        total++; if (to_rises !== 24) begin bad++; $display("[TB] FAIL timeout_bck_rises: got %0d want 24", to_rises); end
        wait_not_busy(400, ok);
        d1 = (load_q.size() > 1) ? load_q[1] : 5'h00;
        total++; if (!ok || load_cnt !== 2) begin bad++; $display("[TB] FAIL timeout_next_load: idle=%0d loads=%0d want 1 2", ok, load_cnt); end
        total++; if (d1 !== 5'h10) begin bad++; $display("[TB] FAIL timeout_kept_fifo: got %h want 10", d1); end
        total++; if (fd_cnt !== 1 || un_cnt !== 0 || to_cnt !== 1) begin bad++; $display("[TB] FAIL timeout_events: fd=%0d un=%0d to=%0d want 1 0 1", fd_cnt, un_cnt, to_cnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_underrun();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_pdm_tx_scheduler.md
Name: ir_pdm_tx_scheduler

Overview:
- Sequences the IR PDM transmit path: buffers 5-bit IR symbols from a host stream and generates the ock/bck strobes.
- Drives load/din into one ir_pdm_modulator and waits on its done for each symbol.
- Frames symbols via a last flag and inserts an inter-frame gap.
- Reports underrun and stuck-modulator timeout.

Parameters:
- OCK_HALF, 2, clk cycles per ock half-period (ock period = 2*OCK_HALF clk).
- BCK_HALF, 64, clk cycles per bck half-period; must be >= 2*OCK_HALF.
- FIFO_DEPTH, 4, symbol FIFO entries, power of two, >= 2.
- GAP_BCK, 2, bck rising edges of idle between frames.
- TIMEOUT_BCK, 24, bck rising edges allowed in WAIT_DONE before abort (>= 17).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset (see Behaviour)
- en  in  1  allow new symbol starts
- s_valid  in  1  symbol offered
- s_ready  out  1  FIFO can accept (= !full)
- s_data  in  5  IR symbol
- s_last  in  1  symbol ends a frame
- ock  out  1  oversample clock to modulator, square wave
- bck  out  1  bit clock to modulator, square wave
- load  out  1  one-cycle load strobe to modulator
- mod_din  out  5  symbol to modulator
- mod_done  in  1  modulator done (level)
- busy  out  1  state != IDLE or FIFO non-empty
- frame_done  out  1  one-cycle pulse, frame finished
- underrun  out  1  one-cycle pulse, FIFO empty mid-frame
- timeout  out  1  one-cycle pulse, WAIT_DONE abort

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk.
- Reset values: ock=0, bck=0, load=0, mod_din=5'h10, s_ready=1, busy=0, all pulses 0, FIFO empty, state IDLE, counters 0.
- Dividers are free-running from reset: ock toggles every OCK_HALF clk, bck every BCK_HALF clk.
- Internal bck_rise is a one-cycle flag on the clk where bck goes 0->1.
- FIFO: push when s_valid&&s_ready and stores {s_last,s_data}. Pop only in LOAD. Push and pop in the same cycle are both honoured. s_ready is registered-free (= !full) and is 0 when full.
- IDLE: if en && !empty -> LOAD.
- LOAD (1 cycle): load=1; mod_din<=head data (held until next LOAD); pop; latch cur_last -> ARM.
- ARM (1 cycle): blanking while the modulator sigma settles; mod_done ignored -> WAIT_DONE; clear timeout counter.
- WAIT_DONE:
  - On mod_done=1:
    - if cur_last -> GAP with frame_done=1.
    - else if !empty -> LOAD (en not required mid-frame).
    - else -> IDLE with underrun=1.
  - Else, increment timeout counter on each bck_rise. When it reaches TIMEOUT_BCK -> IDLE with timeout=1; the FIFO is kept.
- GAP: count bck_rise; after GAP_BCK -> IDLE.
- Symbol 5'h10 completes immediately (done seen in WAIT_DONE, 3 clk after LOAD).
- en deassert mid-frame does not abort; it only blocks leaving IDLE.
- Reset mid-operation returns everything to reset values on the same edge; the FIFO content is discarded.
- Latency: LOAD occurs 1 clk after IDLE sees a non-empty FIFO; back-to-back symbols have 2 clk (LOAD, ARM) of overhead plus the modulator run time.

Decomposition:
- Package ir_pdm_pkg: state enum {IDLE, LOAD, ARM, WAIT_DONE, GAP}; IR_SYM_IDLE=5'h10; IR_SYM_W=5.
- Sub-module pdm_clk_div (parameter HALF; outputs square wave + rise strobe), instanced twice for ock and bck.
- The FIFO is inline.

Test Plan (bench instantiates ir_pdm_modulator as DUT load; OCK_HALF=2, BCK_HALF=8):
- Reset: rstn low mid-WAIT_DONE -> outputs return to reset values immediately; s_ready=1, mod_din=5'h10, ock=bck=0.
- Single frame {5'h14,last}:
  - load pulse 1 cycle with mod_din=5'h14.
  - mod_done rises after 4 bck rises.
  - frame_done 1 pulse.
  - GAP_BCK=2 bck rises, then busy=0.
- Three-symbol frame 5'h0C, 5'h10, 5'h1F(last) pushed back-to-back:
  - three loads in order.
  - 5'h10 spends 0 bck in WAIT_DONE.
  - exactly one frame_done.
- FIFO full: push 5 symbols with FIFO_DEPTH=4 while en=0 -> s_ready=0 after 4th. 5th is held by the source and accepted after the first pop once en=1.
- Underrun: push 5'h12 without last, no further data -> underrun pulse when done, state IDLE, frame_done never asserted.
- Timeout: force mod_done=0 after load -> timeout pulse at 24th bck rise, IDLE. The next queued symbol loads if en=1.
